// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, debounce
// state encodings and the amount width.
package atm_pkg;

    localparam int AMOUNT_W = 32;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [3:0] {
        WAIT_PRESS  = 4'b0001,
        DEB_PRESS   = 4'b0010,
        HELD        = 4'b0100,
        DEB_RELEASE = 4'b1000
    } deb_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code < 4'd10;
    endfunction

endpackage

// File: rtl/atm_key_debounce.sv
// Keypad debouncer: one-hot press/release FSM with a stability counter.
// key_event is a one-cycle combinational pulse so the consumer can register on it.
module atm_key_debounce
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_event,
    output logic [3:0] key_event_code
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    deb_state_t state, next_state;
    logic [7:0] cnt, next_cnt;
    logic [3:0] code, next_code;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
            code  <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            code  <= next_code;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_code  = code;
        unique case (state)
            WAIT_PRESS: begin
                if (key_valid) begin
                    next_state = DEB_PRESS;
                    next_cnt   = 8'd1;
                    next_code  = key_code;
                end
            end
            DEB_PRESS: begin
                if (!key_valid) begin
                    next_state = WAIT_PRESS;
                end else if (key_code != code) begin
                    next_cnt  = 8'd1;
                    next_code = key_code;
                end else if (cnt == CNT_LAST) begin
                    next_state = HELD;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            HELD: begin
                if (!key_valid) begin
                    next_state = DEB_RELEASE;
                    next_cnt   = 8'd1;
                end
            end
            DEB_RELEASE: begin
                if (key_valid) begin
                    next_state = HELD;
                end else if (cnt == CNT_LAST) begin
                    next_state = WAIT_PRESS;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            default: begin
                next_state = WAIT_PRESS;
                next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        key_event      = (state == DEB_PRESS) && key_valid && (key_code == code)
                         && (cnt == CNT_LAST);
        key_event_code = code;
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry: debounced PIN digit strobes and a decimal amount
// accumulator committed on ENTER. All outputs are registered.
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                amountMode,
    output logic [3:0]          digit,
    output logic                stbDigit,
    output logic [AMOUNT_W-1:0] amount,
    output logic                stbAmount,
    output logic [AMOUNT_W-1:0] entryValue,
    output logic [3:0]          entryDigits,
    output logic                digitRejected,
    output logic                cancel
);

    localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

    logic                key_event;
    logic [3:0]          key_event_code;

    logic [3:0]          next_digit;
    logic                next_stb_digit;
    logic [AMOUNT_W-1:0] next_amount;
    logic                next_stb_amount;
    logic [AMOUNT_W-1:0] next_value;
    logic [3:0]          next_digits;
    logic                next_rejected;
    logic                next_cancel;

    atm_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock         (clock),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_event     (key_event),
        .key_event_code(key_event_code)
    );

    always_comb begin
        next_digit      = digit;
        next_stb_digit  = 1'b0;
        next_amount     = amount;
        next_stb_amount = 1'b0;
        next_value      = entryValue;
        next_digits     = entryDigits;
        next_rejected   = 1'b0;
        next_cancel     = 1'b0;

        // The accumulator only lives while amount entry is selected.
        if (!amountMode) begin
            next_value  = '0;
            next_digits = '0;
        end

        if (key_event) begin
            if (key_event_code == KEY_CANCEL) begin
                next_cancel = 1'b1;
                next_value  = '0;
                next_digits = '0;
            end else if (is_digit(key_event_code)) begin
                if (!amountMode) begin
                    next_digit     = key_event_code;
                    next_stb_digit = 1'b1;
                end else if (!(entryValue == '0 && key_event_code == 4'd0)) begin
                    if (entryDigits < MAX_D) begin
                        next_value  = entryValue * AMOUNT_W'(10) + AMOUNT_W'(key_event_code);
                        next_digits = entryDigits + 4'd1;
                    end else begin
                        next_rejected = 1'b1;
                    end
                end
            end else if (amountMode && key_event_code == KEY_ENTER && entryDigits != '0) begin
                next_amount     = entryValue;
                next_stb_amount = 1'b1;
                next_value      = '0;
                next_digits     = '0;
            end else if (amountMode && key_event_code == KEY_CLEAR) begin
                next_value  = '0;
                next_digits = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            digit         <= '0;
            stbDigit      <= 1'b0;
            amount        <= '0;
            stbAmount     <= 1'b0;
            entryValue    <= '0;
            entryDigits   <= '0;
            digitRejected <= 1'b0;
            cancel        <= 1'b0;
        end else begin
            digit         <= next_digit;
            stbDigit      <= next_stb_digit;
            amount        <= next_amount;
            stbAmount     <= next_stb_amount;
            entryValue    <= next_value;
            entryDigits   <= next_digits;
            digitRejected <= next_rejected;
            cancel        <= next_cancel;
        end
    end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: PIN strobes, bounce rejection,
// amount accumulation, CLEAR/CANCEL and reset during a press.
module tb_atm_keypad_entry;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        amountMode;
    logic [3:0]  digit;
    logic        stbDigit;
    logic [31:0] amount;
    logic        stbAmount;
    logic [31:0] entryValue;
    logic [3:0]  entryDigits;
    logic        digitRejected;
    logic        cancel;

    int checks = 0;
    int errors = 0;
    int n_dig = 0, n_amt = 0, n_rej = 0, n_can = 0, n_coinc = 0;

    atm_keypad_entry #(
        .DEBOUNCE_CYCLES(4),
        .MAX_DIGITS     (9)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .amountMode   (amountMode),
        .digit        (digit),
        .stbDigit     (stbDigit),
        .amount       (amount),
        .stbAmount    (stbAmount),
        .entryValue   (entryValue),
        .entryDigits  (entryDigits),
        .digitRejected(digitRejected),
        .cancel       (cancel)
    );

    always #5 clock = ~clock;

    // Strobe tally, sampled mid-cycle.
    always @(negedge clock) begin
        n_dig <= n_dig + int'(stbDigit);
        n_amt <= n_amt + int'(stbAmount);
        n_rej <= n_rej + int'(digitRejected);
        n_can <= n_can + int'(cancel);
        if ((int'(stbDigit) + int'(stbAmount) + int'(digitRejected) + int'(cancel)) > 1)
            n_coinc <= n_coinc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        repeat (8) tick();
        key_valid = 1'b0;
        repeat (8) tick();
    endtask

    logic [3:0] amt_keys [6] = '{4'd0, 4'd0, 4'd2, 4'd5, 4'd0, 4'd0};
    int         amt_vals [6] = '{0, 0, 2, 25, 250, 2500};
    int         amt_digs [6] = '{0, 0, 1, 2, 3, 4};

    initial begin
        int s_dig, s_amt, s_rej, s_can;
        logic [8:0] press_pat;
        logic [5:0] rel_pat;

        reset      = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        amountMode = 1'b0;
        repeat (3) tick();
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_amount", amount, 32'd0);
        check("rst_value", entryValue, 32'd0);
        check("rst_digits", 32'(entryDigits), 32'd0);
        check("rst_strobes", {28'd0, stbDigit, stbAmount, digitRejected, cancel}, 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Clean PIN digits with exact strobe timing.
        s_dig = n_dig; s_amt = n_amt; s_rej = n_rej; s_can = n_can;
        for (int k = 1; k <= 4; k++) begin
            key_code  = 4'(k);
            key_valid = 1'b1;
            repeat (3) tick();
            check($sformatf("pin%0d_early", k), 32'(stbDigit), 32'd0);
            tick();
            check($sformatf("pin%0d_stb", k), 32'(stbDigit), 32'd1);
            check($sformatf("pin%0d_digit", k), 32'(digit), 32'(k));
            tick();
            check($sformatf("pin%0d_width", k), 32'(stbDigit), 32'd0);
            repeat (3) tick();
            key_valid = 1'b0;
            repeat (8) tick();
        end
        check("pin_count", 32'(n_dig - s_dig), 32'd4);
        check("pin_other", 32'((n_amt - s_amt) + (n_rej - s_rej) + (n_can - s_can)), 32'd0);

        // Bouncy press and release produce a single event.
        s_dig     = n_dig;
        key_code  = 4'd7;
        press_pat = 9'b111101101;
        for (int i = 0; i < 9; i++) begin
            key_valid = press_pat[i];
            tick();
        end
        rel_pat = 6'b000010;
        for (int i = 0; i < 6; i++) begin
            key_valid = rel_pat[i];
            tick();
        end
        repeat (4) tick();
        check("bounce_count", 32'(n_dig - s_dig), 32'd1);
        check("bounce_digit", 32'(digit), 32'd7);
        press(4'd7);
        check("repress_count", 32'(n_dig - s_dig), 32'd2);

        // Amount entry with leading and trailing zeros.
        amountMode = 1'b1;
        s_dig = n_dig; s_amt = n_amt;
        for (int i = 0; i < 6; i++) begin
            press(amt_keys[i]);
            check($sformatf("acc_value%0d", i), entryValue, 32'(amt_vals[i]));
            check($sformatf("acc_digits%0d", i), 32'(entryDigits), 32'(amt_digs[i]));
        end
        press(4'hA);
        check("commit_stb", 32'(n_amt - s_amt), 32'd1);
        check("commit_amount", amount, 32'd2500);
        check("commit_clear", entryValue, 32'd0);
        check("commit_digits", 32'(entryDigits), 32'd0);

        // Full entry: the tenth digit is rejected.
        s_rej = n_rej;
        for (int i = 0; i < 9; i++) press(4'd9);
        check("full_value", entryValue, 32'd999_999_999);
        check("full_digits", 32'(entryDigits), 32'd9);
        press(4'd7);
        check("full_reject", 32'(n_rej - s_rej), 32'd1);
        check("full_hold", entryValue, 32'd999_999_999);
        press(4'hA);
        check("full_amount", amount, 32'h3B9A_C9FF);
        check("amt_no_pin_stb", 32'(n_dig - s_dig), 32'd0);

        // CLEAR, CANCEL and an empty ENTER.
        press(4'd4);
        press(4'd2);
        check("clr_pre", entryValue, 32'd42);
        press(4'hB);
        check("clr_value", entryValue, 32'd0);
        check("clr_digits", 32'(entryDigits), 32'd0);
        press(4'd8);
        press(4'hA);
        check("clr_amount", amount, 32'd8);
        s_can = n_can; s_amt = n_amt;
        press(4'd5);
        check("can_pre", entryValue, 32'd5);
        press(4'hC);
        check("can_pulse", 32'(n_can - s_can), 32'd1);
        check("can_value", entryValue, 32'd0);
        check("can_amount", amount, 32'd8);
        press(4'hA);
        check("empty_enter", 32'(n_amt - s_amt), 32'd0);
        check("empty_amount", amount, 32'd8);

        // Reset in the middle of a press with the key still down.
        amountMode = 1'b0;
        key_code   = 4'd6;
        key_valid  = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("midrst_digit", 32'(digit), 32'd0);
        check("midrst_amount", amount, 32'd0);
        check("midrst_strobes", {28'd0, stbDigit, stbAmount, digitRejected, cancel}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("midrst_early", 32'(stbDigit), 32'd0);
        tick();
        check("midrst_stb", 32'(stbDigit), 32'd1);
        check("midrst_digit6", 32'(digit), 32'd6);
        key_valid = 1'b0;
        repeat (8) tick();

        check("strobe_exclusive", 32'(n_coinc), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
